// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the stalling pipelined CPU.
// It generates the fetch PC and drives a req/ack instruction-memory port.
// Fetched words go into a 2-entry queue, and the queue head feeds the IF/ID registers.
// A redirect resolved in ID flushes the queue and restarts fetch at the new target.
// Optional feature: define IF_FETCH_PERF_EN to add the perf_fetch_cnt/perf_flush_cnt counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] flush_addr_q, flush_addr_d;
  logic [31:0] qpc_q   [2];
  logic [31:0] qinst_q [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop, tail;
  logic [31:0] redirect_tgt;

  // The redirect target is forced word aligned, and a redirect empties the queue.
  // Pushes come only from a non-discarded ack, and a pop needs a valid head that is not stalled.
  always_comb begin
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    push         = (state_q == FETCH) && imem_ack && !redirect;
    pop          = (count_q != 2'd0) && !stall && !redirect;
    tail         = head_q ^ count_q[0];
    count_d      = count_q;
    head_d       = head_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head_d = ~head_q;
      end
    end
  end

  // Fetch FSM next state. A request is launched only while a queue slot is still free after
  // this cycle, so the single outstanding word always has room to land.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    flush_addr_d = flush_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          state_d    = FETCH;
        end else if (count_d <= 2'd1) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack && redirect) begin
          fetch_pc_d = redirect_tgt;
          state_d    = FETCH;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_INC;
          state_d    = (count_d <= 2'd1) ? FETCH : IDLE;
        end else if (redirect) begin
          fetch_pc_d   = redirect_tgt;
          flush_addr_d = fetch_pc_q;
          state_d      = FLUSH;
        end
      end
      FLUSH: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: FSM state, fetch PC, the address held during a flush, and the queue pointers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      flush_addr_q <= RESET_PC;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      flush_addr_q <= flush_addr_d;
      head_q       <= head_d;
      count_q      <= count_d;
    end
  end

  // Queue storage: each accepted word is written at the tail together with its PC.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 2; i++) begin
        qpc_q[i]   <= 32'd0;
        qinst_q[i] <= 32'd0;
      end
    end else if (push) begin
      qpc_q[tail]   <= fetch_pc_q;
      qinst_q[tail] <= imem_rdata;
    end
  end

  // Outputs come straight from registers: the request depends only on state, and the head
  // entry feeds IF/ID with no combinational path from stall.
  always_comb begin
    imem_req   = (state_q != IDLE);
    imem_addr  = (state_q == FLUSH) ? flush_addr_q : fetch_pc_q;
    inst_out   = qinst_q[head_q];
    pc_out     = qpc_q[head_q];
    inst_valid = (count_q != 2'd0);
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  // Counts accepted (non-discarded) fetches and the cycles that carry a redirect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_fetch_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (push) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (redirect) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  // Drives the counter values onto the output ports.
  always_comb begin
    perf_fetch_cnt = perf_fetch_q;
    perf_flush_cnt = perf_flush_q;
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit.
// A behavioural memory returns addr>>2 after a configurable number of wait cycles.
// It runs a fixed vector table, hand-written corner sequences, and a randomized run that is
// checked against an instruction-stream model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  int   memLat;
  int   memWait;
  bit   memRandLat;
  bit   memManual;
  logic manualAck;
  logic [31:0] manualData;

  typedef struct {
    logic        stall;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInst;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs [13];

  if_fetch_unit dut (
    .clk         (clk),
    .clrn        (clrn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Memory response for the coming edge; called at a negedge, where the request is stable.
  task automatic driveMem();
    if (memManual) begin
      imem_ack   = manualAck;
      imem_rdata = manualData;
    end else if (imem_req) begin
      if (memWait >= memLat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr >> 2;
        memWait    = 0;
        if (memRandLat) memLat = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        memWait++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      memWait    = 0;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    driveMem();
  endtask

  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycleStep(input logic s, input logic r, input logic [31:0] rpc);
    applyStimulus(s, r, rpc);
    stepClock();
  endtask

  // Holds reset for two cycles and releases it at a negedge.
  task automatic doReset(input int lat);
    clrn        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    memManual   = 1'b0;
    memRandLat  = 1'b0;
    memLat      = lat;
    memWait     = 0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    logic [31:0] expPc;
    logic        prevRedirect;
    logic        prevPending;
    logic [31:0] prevAddr;
    logic        s, r;
    logic [31:0] rpc;
    int          consumed;

    // Vectors for reset release and a 5-cycle stall with zero-wait memory.
    // Each row lists the outputs seen at this negedge, then the stall driven for the next edge.
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h00, 32'h0, 1'b1, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 32'h04, 32'h1, 1'b1, 32'h08};
    vecs[4]  = '{1'b1, 1'b1, 32'h08, 32'h2, 1'b1, 32'h0C};
    vecs[5]  = '{1'b1, 1'b1, 32'h08, 32'h2, 1'b0, 32'h10};
    vecs[6]  = '{1'b1, 1'b1, 32'h08, 32'h2, 1'b0, 32'h10};
    vecs[7]  = '{1'b1, 1'b1, 32'h08, 32'h2, 1'b0, 32'h10};
    vecs[8]  = '{1'b1, 1'b1, 32'h08, 32'h2, 1'b0, 32'h10};
    vecs[9]  = '{1'b0, 1'b1, 32'h08, 32'h2, 1'b0, 32'h10};
    vecs[10] = '{1'b0, 1'b1, 32'h0C, 32'h3, 1'b1, 32'h10};
    vecs[11] = '{1'b0, 1'b1, 32'h10, 32'h4, 1'b1, 32'h14};
    vecs[12] = '{1'b0, 1'b1, 32'h14, 32'h5, 1'b1, 32'h18};

    @(negedge clk);
    doReset(0);
    for (int i = 0; i < 13; i++) begin
      checkOutput($sformatf("vec%0d_valid", i), inst_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d_req", i), imem_req, vecs[i].expReq);
      checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_pc", i), pc_out, vecs[i].expPc);
      checkOutput($sformatf("vec%0d_inst", i), inst_out, vecs[i].expInst);
      cycleStep(vecs[i].stall, 1'b0, 32'd0);
    end

    // 3-cycle memory, redirect to 0x100 in the second wait cycle.
    doReset(3);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s3_req_issue", imem_req, 1);
    cycleStep(1'b0, 1'b0, 32'd0);
    cycleStep(1'b0, 1'b1, 32'h100);
    checkOutput("s3_flush_req", imem_req, 1);
    checkOutput("s3_flush_addr", imem_addr, 32'h0);
    checkOutput("s3_flush_valid", inst_valid, 0);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s3_flush_addr2", imem_addr, 32'h0);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s3_refetch_addr", imem_addr, 32'h100);
    checkOutput("s3_refetch_req", imem_req, 1);
    checkOutput("s3_refetch_valid", inst_valid, 0);
`ifdef IF_FETCH_PERF_EN
    checkOutput("s3_perf_fetch", perf_fetch_cnt, 32'd0);
    checkOutput("s3_perf_flush", perf_flush_cnt, 32'd1);
`endif
    for (int i = 0; i < 12; i++) begin
      if (inst_valid) break;
      cycleStep(1'b0, 1'b0, 32'd0);
    end
    checkOutput("s3_return_valid", inst_valid, 1);
    checkOutput("s3_return_pc", pc_out, 32'h100);
    checkOutput("s3_return_inst", inst_out, 32'h40);

    // Redirect with stall=1 and two queued words; 0x203 must fetch 0x200.
    doReset(0);
    cycleStep(1'b1, 1'b0, 32'd0);
    cycleStep(1'b1, 1'b0, 32'd0);
    cycleStep(1'b1, 1'b0, 32'd0);
    checkOutput("s4_full_req", imem_req, 0);
    checkOutput("s4_full_valid", inst_valid, 1);
    cycleStep(1'b1, 1'b1, 32'h203);
    checkOutput("s4_cleared_valid", inst_valid, 0);
    checkOutput("s4_addr", imem_addr, 32'h200);
    checkOutput("s4_req", imem_req, 1);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s4_pc", pc_out, 32'h200);
    checkOutput("s4_inst", inst_out, 32'h80);

    // Reset pulse while a request is outstanding, then a stale ack.
    doReset(1);
    cycleStep(1'b1, 1'b1, 32'h40);
    cycleStep(1'b1, 1'b0, 32'd0);
    cycleStep(1'b1, 1'b0, 32'd0);
    cycleStep(1'b1, 1'b0, 32'd0);
    checkOutput("s5_pre_pc", pc_out, 32'h40);
    checkOutput("s5_pre_req", imem_req, 1);
    #2 clrn = 1'b0;
    #1;
    checkOutput("s5_rst_req", imem_req, 0);
    checkOutput("s5_rst_valid", inst_valid, 0);
    checkOutput("s5_rst_pc", pc_out, 32'h0);
    checkOutput("s5_rst_inst", inst_out, 32'h0);
    checkOutput("s5_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    clrn       = 1'b1;
    memManual  = 1'b1;
    manualAck  = 1'b1;
    manualData = 32'hDEAD_BEEF;
    cycleStep(1'b0, 1'b0, 32'd0);
    memManual = 1'b0;
    memLat    = 0;
    memWait   = 0;
    checkOutput("s5_stale_valid", inst_valid, 0);
    checkOutput("s5_restart_addr", imem_addr, 32'h0);
    checkOutput("s5_restart_req", imem_req, 1);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s5_first_pc", pc_out, 32'h0);
    checkOutput("s5_first_inst", inst_out, 32'h0);

    // PC wrap at 0xFFFF_FFFC.
    doReset(0);
    cycleStep(1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("s6_addr_top", imem_addr, 32'hFFFF_FFFC);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s6_addr_wrap", imem_addr, 32'h0);
    checkOutput("s6_pc_top", pc_out, 32'hFFFF_FFFC);
    checkOutput("s6_inst_top", inst_out, 32'h3FFF_FFFF);
    cycleStep(1'b0, 1'b0, 32'd0);
    checkOutput("s6_pc_wrap", pc_out, 32'h0);
    checkOutput("s6_inst_wrap", inst_out, 32'h0);

    // Randomized run: the consumed stream must be sequential from the last target.
    doReset(1);
    memRandLat   = 1'b1;
    expPc        = 32'h0;
    prevRedirect = 1'b0;
    prevPending  = 1'b0;
    prevAddr     = 32'h0;
    consumed     = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prevRedirect) checkOutput("rnd_post_redirect_valid", inst_valid, 0);
      if (prevPending) begin
        checkOutput("rnd_req_hold", imem_req, 1);
        checkOutput("rnd_addr_hold", imem_addr, prevAddr);
      end
      s   = ($urandom_range(0, 9) < 3);
      r   = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      applyStimulus(s, r, rpc);
      if (inst_valid && !s && !r) begin
        checkOutput("rnd_pc", pc_out, expPc);
        checkOutput("rnd_inst", inst_out, expPc >> 2);
        expPc = expPc + 32'd4;
        consumed++;
      end
      if (r) expPc = rpc & 32'hFFFF_FFFC;
      prevRedirect = r;
      prevPending  = imem_req && !imem_ack;
      prevAddr     = imem_addr;
      stepClock();
    end
    checkOutput("rnd_progress", (consumed > 200) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
